// File: rtl/line_scheduler.sv
// Line scheduler: fetches each line of a job from source memory, runs it through an
// external engine under a per-line watchdog and stores the result to destination memory.
module line_scheduler #(
    parameter int unsigned NLINES  = 64,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned AW = (NLINES > 1) ? $clog2(NLINES) : 1,
    localparam int unsigned CW = $clog2(NLINES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go_i,
    input  logic [CW-1:0] num_lines_i,
    output logic          src_rd_o,
    output logic [AW-1:0] src_addr_o,
    input  logic [24:0]   src_data_i,
    output logic          eng_start_o,
    output logic [24:0]   eng_line_o,
    input  logic          eng_done_i,
    input  logic [24:0]   eng_result_i,
    output logic          dst_we_o,
    output logic [AW-1:0] dst_addr_o,
    output logic [24:0]   dst_data_o,
    output logic          busy_o,
    output logic          finish_o,
    output logic [CW-1:0] line_count_o,
    output logic          timeout_err_o
);

    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WdLast = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MaxLines = CW'(NLINES);
    localparam logic [24:0] TimeoutWord = 25'h1FFFFFF;

    typedef enum logic [2:0] {
        StIdle, StFetch, StWaitData, StLaunch, StRun, StStore, StNext, StDone
    } state_e;

    state_e        state_q;
    logic [AW-1:0] idx_q;
    logic [CW-1:0] total_q;
    logic [WW-1:0] wdog_q;
    logic [CW-1:0] line_count_q;
    logic          timeout_err_q;
    logic          src_rd_q, eng_start_q, dst_we_q, finish_q;
    logic [AW-1:0] src_addr_q, dst_addr_q;
    logic [24:0]   eng_line_q, dst_data_q;

    logic [CW-1:0] num_clamped;
    logic [CW-1:0] idx_plus1;

    always_comb begin
        num_clamped = (num_lines_i > MaxLines) ? MaxLines : num_lines_i;
        idx_plus1   = CW'(idx_q) + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            total_q       <= '0;
            wdog_q        <= '0;
            line_count_q  <= '0;
            timeout_err_q <= 1'b0;
            src_rd_q      <= 1'b0;
            eng_start_q   <= 1'b0;
            dst_we_q      <= 1'b0;
            finish_q      <= 1'b0;
            src_addr_q    <= '0;
            dst_addr_q    <= '0;
            eng_line_q    <= '0;
            dst_data_q    <= '0;
        end else begin
            // Strobes are registered and default low, so each is a clean one-cycle pulse.
            src_rd_q    <= 1'b0;
            eng_start_q <= 1'b0;
            dst_we_q    <= 1'b0;
            finish_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go_i) begin
                        idx_q         <= '0;
                        line_count_q  <= '0;
                        timeout_err_q <= 1'b0;
                        total_q       <= num_clamped;
                        if (num_clamped == '0) begin
                            state_q <= StDone;
                        end else begin
                            src_rd_q   <= 1'b1;
                            src_addr_q <= '0;
                            state_q    <= StFetch;
                        end
                    end
                end
                StFetch: state_q <= StWaitData;
                StWaitData: begin
                    eng_line_q  <= src_data_i;
                    eng_start_q <= 1'b1;
                    state_q     <= StLaunch;
                end
                StLaunch: begin
                    wdog_q  <= '0;
                    state_q <= StRun;
                end
                StRun: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (eng_done_i) begin
                        dst_data_q <= eng_result_i;
                        dst_addr_q <= idx_q;
                        dst_we_q   <= 1'b1;
                        state_q    <= StStore;
                    end else if (wdog_q == WdLast) begin
                        dst_data_q    <= TimeoutWord;
                        dst_addr_q    <= idx_q;
                        dst_we_q      <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= StStore;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                StStore: begin
                    line_count_q <= line_count_q + CW'(1);
                    state_q      <= StNext;
                end
                StNext: begin
                    if (idx_plus1 == total_q) begin
                        state_q <= StDone;
                    end else begin
                        idx_q      <= idx_q + AW'(1);
                        src_addr_q <= idx_q + AW'(1);
                        src_rd_q   <= 1'b1;
                        state_q    <= StFetch;
                    end
                end
                StDone: begin
                    finish_q <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign src_rd_o      = src_rd_q;
    assign src_addr_o    = src_addr_q;
    assign eng_start_o   = eng_start_q;
    assign eng_line_o    = eng_line_q;
    assign dst_we_o      = dst_we_q;
    assign dst_addr_o    = dst_addr_q;
    assign dst_data_o    = dst_data_q;
    assign finish_o      = finish_q;
    assign line_count_o  = line_count_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_line_scheduler.sv
// Randomized bench for line_scheduler: memory/engine responders plus a timeline model
// that predicts the cycle and content of every strobe of each job.
module tb_line_scheduler;

    localparam int TO = 16;

    typedef struct {
        int          cyc;
        int          addr;
        logic [24:0] val;
    } ev_t;

    logic        clk, rst, go_i;
    logic [6:0]  num_lines_i;
    logic        src_rd_o, eng_start_o, eng_done_i, dst_we_o, busy_o, finish_o, timeout_err_o;
    logic [5:0]  src_addr_o, dst_addr_o;
    logic [24:0] src_data_i, eng_line_o, eng_result_i, dst_data_o;
    logic [6:0]  line_count_o;

    line_scheduler #(.NLINES(64), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .go_i         (go_i),
        .num_lines_i  (num_lines_i),
        .src_rd_o     (src_rd_o),
        .src_addr_o   (src_addr_o),
        .src_data_i   (src_data_i),
        .eng_start_o  (eng_start_o),
        .eng_line_o   (eng_line_o),
        .eng_done_i   (eng_done_i),
        .eng_result_i (eng_result_i),
        .dst_we_o     (dst_we_o),
        .dst_addr_o   (dst_addr_o),
        .dst_data_o   (dst_data_o),
        .busy_o       (busy_o),
        .finish_o     (finish_o),
        .line_count_o (line_count_o),
        .timeout_err_o(timeout_err_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [24:0] src_mem [64];
    logic [24:0] key;
    bit          spur;
    ev_t         exp_rd[$], exp_st[$], exp_wr[$];
    int          exp_fin[$];
    int          eng_d_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory and engine responders, plus event checking against the predicted timeline.
    initial begin
        ev_t         e;
        bit          rd_pend;
        logic [5:0]  rd_addr;
        int          done_at, d;
        logic [24:0] done_val;
        rd_pend = 0; rd_addr = '0; done_at = -1; done_val = '0;
        src_data_i = '0; eng_done_i = 1'b0; eng_result_i = '0;
        forever begin
            @(posedge clk); #1;
            src_data_i = rd_pend ? src_mem[rd_addr] : 25'($urandom());
            rd_pend = src_rd_o && !rst;
            rd_addr = src_addr_o;

            eng_done_i = 1'b0;
            eng_result_i = 25'($urandom());
            if (cyc == done_at) begin
                eng_done_i = 1'b1;
                eng_result_i = done_val;
            end else if (spur && (!busy_o || eng_start_o) && ($urandom_range(0, 1) == 1)) begin
                eng_done_i = 1'b1;
            end
            if (eng_start_o) begin
                d = (eng_d_q.size() > 0) ? eng_d_q.pop_front() : 0;
                done_at = (d > 0) ? cyc + d : -1;
                done_val = eng_line_o ^ key;
            end

            if (src_rd_o) begin
                if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", 32'(src_addr_o), e.addr);
                end
            end
            if (eng_start_o) begin
                if (exp_st.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    e = exp_st.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    chk("start_line", 32'(eng_line_o), 32'(e.val));
                end
            end
            if (dst_we_o) begin
                if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", 32'(dst_addr_o), e.addr);
                    chk("wr_data", 32'(dst_data_o), 32'(e.val));
                end
            end
            if (finish_o) begin
                if (exp_fin.size() == 0) chk("finish_unexpected", 1, 0);
                else chk("finish_cycle", cyc, exp_fin.pop_front());
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_finish"}, 32'(finish_o), 0);
        chk({tag, "_strobes"}, 32'({src_rd_o, eng_start_o, dst_we_o}), 0);
        chk({tag, "_line_count"}, 32'(line_count_o), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err_o), 0);
        chk({tag, "_eng_line"}, 32'(eng_line_o), 0);
        chk({tag, "_addrs"}, 32'({src_addr_o, dst_addr_o}), 0);
        chk({tag, "_dst_data"}, 32'(dst_data_o), 0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_missing_rd"}, exp_rd.size(), 0);
        chk({tag, "_missing_start"}, exp_st.size(), 0);
        chk({tag, "_missing_wr"}, exp_wr.size(), 0);
        chk({tag, "_missing_finish"}, exp_fin.size(), 0);
        exp_rd.delete(); exp_st.delete(); exp_wr.delete(); exp_fin.delete();
        eng_d_q.delete();
    endtask

    // dmode: >0 fixed engine delay, 0 engine never answers, <0 random delay per line.
    task automatic run_job(input int n, input int dmode, input logic [24:0] kv,
                           input bit preset, input bit noise, input int abort);
        int  nn, t, t0, fin, dd, abort_cyc;
        bit  err;
        ev_t e;
        nn = (n > 64) ? 64 : n;
        if (!preset) for (int i = 0; i < 64; i++) src_mem[i] = 25'($urandom());
        key = kv;
        @(posedge clk); #1;
        t0 = cyc;
        go_i = 1'b1;
        num_lines_i = 7'(n);
        t = t0 + 1; err = 0; abort_cyc = -1;
        for (int k = 0; k < nn; k++) begin
            dd = (dmode < 0) ? int'($urandom_range(1, TO + 2)) : dmode;
            eng_d_q.push_back(dd);
            e.cyc = t; e.addr = k; e.val = '0;
            exp_rd.push_back(e);
            e.cyc = t + 2; e.val = src_mem[k];
            exp_st.push_back(e);
            if (k == abort) begin
                abort_cyc = t + 5;
                break;
            end
            if (dd == 0 || dd > TO) begin
                e.cyc = t + 2 + TO + 1; e.val = 25'h1FFFFFF; err = 1;
            end else begin
                e.cyc = t + 2 + dd + 1; e.val = src_mem[k] ^ kv;
            end
            exp_wr.push_back(e);
            t = e.cyc + 2;
        end
        fin = t + 1;
        if (abort_cyc >= 0) begin
            while (cyc < abort_cyc) begin
                @(posedge clk); #1;
                go_i = 1'b0;
            end
            rst = 1'b1;
            #1;
            reset_checks("abort");
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b0;
            check_drained("abort");
            repeat (12) @(posedge clk);
            #1;
        end else begin
            exp_fin.push_back(fin);
            while (cyc < fin + 1) begin
                @(posedge clk); #1;
                go_i = noise && (cyc <= fin - 1) && ($urandom_range(0, 2) == 0);
                if (go_i) num_lines_i = 7'($urandom());
            end
            check_drained("job");
            chk("line_count", 32'(line_count_o), nn);
            chk("timeout_err", 32'(timeout_err_o), 32'(err));
            chk("busy_after", 32'(busy_o), 0);
            repeat (3) @(posedge clk);
            #1;
            chk("line_count_hold", 32'(line_count_o), nn);
            chk("timeout_err_hold", 32'(timeout_err_o), 32'(err));
        end
    endtask

    initial begin
        rst = 1'b0; go_i = 1'b0; num_lines_i = '0; spur = 0; key = '0;
        #3 rst = 1'b1;
        #2 reset_checks("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        src_mem[0] = 25'h0000001; src_mem[1] = 25'h1555555; src_mem[2] = 25'h1FFFFFF;
        run_job(3, 5, 25'h0, 1, 0, -1);
        run_job(64, 1, 25'($urandom()), 0, 0, -1);
        run_job(2, 0, 25'h0, 0, 0, -1);
        run_job(0, 1, 25'h0, 0, 0, -1);
        run_job(2, TO, 25'($urandom()), 0, 0, -1);
        run_job(1, TO + 1, 25'($urandom()), 0, 0, -1);
        run_job(100, 1, 25'($urandom()), 0, 0, -1);
        run_job(4, 10, 25'($urandom()), 0, 0, 2);
        run_job(1, 3, 25'($urandom()), 0, 0, -1);
        spur = 1;
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 12)), -1, 25'($urandom()), 0, 1, -1);
        end
        spur = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_scheduler.md
LINE_SCHEDULER -- requirements
Module: line_scheduler

Interface
REQ-001 Parameter NLINES, default 64: maximum lines per job; this is the memory depth.
REQ-002 Parameter TIMEOUT, default 1024: maximum cycles allowed per line in RUN.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 go  in  1  job start request; sampled in IDLE only.
REQ-006 num_lines  in  7  number of lines in the job; values 0..64 are legal, and values above 64 are clamped to 64.
REQ-007 src_rd / src_addr  out  1 / 6  source-memory read strobe and line index.
REQ-008 src_data  in  25  source line, valid exactly 1 cycle after src_rd.
REQ-009 eng_start / eng_line  out  1 / 25  one-cycle engine launch pulse and the latched 25-bit line (5x5 bits).
REQ-010 eng_done / eng_result  in  1 / 25  engine completion strobe and its 25-bit result.
REQ-011 dst_we / dst_addr / dst_data  out  1 / 6 / 25  result-memory write strobe, index and data.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 finish  out  1  one-cycle pulse at the end of a job.
REQ-014 line_count  out  7  number of lines stored in the current job.
REQ-015 timeout_err  out  1  sticky timeout flag; cleared by go.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH, WAITDATA, LAUNCH, RUN, STORE, NEXT and DONE.
REQ-017 IDLE SHALL go to FETCH on go=1, and at the same time clear idx, line_count and timeout_err and latch the clamped num_lines.
- Exception: if the latched value is 0, IDLE SHALL go directly to DONE with no memory or engine activity.
REQ-018 FETCH SHALL assert src_rd=1 with src_addr=idx for 1 cycle, then go to WAITDATA.
REQ-019 WAITDATA SHALL capture src_data into eng_line, then go to LAUNCH.
REQ-020 LAUNCH SHALL assert eng_start=1 for exactly 1 cycle, clear the watchdog, then go to RUN.
REQ-021 RUN SHALL wait for eng_done=1, capture eng_result, then go to STORE.
- eng_done SHALL be ignored in every state other than RUN, including the LAUNCH cycle.
REQ-022 The watchdog SHALL increment every cycle in RUN.
- On reaching TIMEOUT-1 with eng_done=0: set timeout_err=1, substitute result 25'h1FFFFFF, go to STORE.
- If eng_done=1 in that same cycle, eng_done wins and no error is flagged.
REQ-023 STORE SHALL assert dst_we=1 with dst_addr=idx and dst_data equal to the captured result for 1 cycle, increment line_count, then go to NEXT.
REQ-024 NEXT SHALL go to DONE when idx+1 equals the latched count; otherwise it SHALL increment idx and go to FETCH.
- idx SHALL never wrap past 63.
REQ-025 DONE SHALL pulse finish=1 for 1 cycle, then go to IDLE.
REQ-026 Latency: with go in cycle 0, src_rd is in cycle 1, eng_start in cycle 3 and RUN starts in cycle 4.
- eng_done in cycle N gives dst_we in cycle N+1 and the next src_rd in cycle N+3.
REQ-027 go SHALL be ignored while busy=1; it SHALL neither restart nor queue a job.
REQ-028 Every strobe output (src_rd, eng_start, dst_we, finish) SHALL be a registered, glitch-free, single-cycle pulse.
REQ-029 line_count and timeout_err SHALL hold their values in IDLE after a job until the next accepted go.

Reset
REQ-030 While rst=1 the block SHALL immediately hold the following values:
- state = IDLE; idx = 0; watchdog = 0;
- all strobes = 0; busy = 0; finish = 0;
- line_count = 0; timeout_err = 0;
- eng_line = 0; dst_addr = 0; dst_data = 0; src_addr = 0.
REQ-031 Reset asserted mid-job SHALL abort the job without a finish pulse; any eng_done arriving afterwards SHALL be ignored.
REQ-032 After rst deasserts, the first go SHALL start a fresh job at idx 0.

Verification
REQ-033 num_lines=3, engine echoes its line after 5 cycles, src holds 25'h0000001, 25'h1555555, 25'h1FFFFFF.
- Required: dst receives the same 3 words at addresses 0..2, line_count=3, a single finish pulse, timeout_err=0.
REQ-034 num_lines=64 with a 1-cycle engine.
- Required: 64 writes at addresses 0..63, no address wrap, line_count=64, finish exactly once.
REQ-035 num_lines=2, engine never asserts eng_done, TIMEOUT=16.
- Required: each line is stored as 25'h1FFFFFF exactly 16 cycles after its RUN entry, and timeout_err=1 after the job.
REQ-036 num_lines=0.
- Required: finish pulses 2 cycles after go, with no src_rd, eng_start or dst_we activity.
REQ-037 num_lines=4; assert rst during the RUN of line 2, then re-issue go with num_lines=1.
- Required: no finish for the aborted job; the new job writes address 0 only, line_count=1.
REQ-038 Spurious eng_done during IDLE/LAUNCH and a second go while busy.
- Required: no effect on any output or on the job sequencing.
